// File: rtl/async_fifo_pkg.sv
// Shared helpers for both pointer stages of the asynchronous FIFO.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Contents: DEF_ADDR_W default address width, ptr_t pointer type,
//           bin2gray / gray2bin conversions on a wide container type.
package async_fifo_pkg;

   localparam int DEF_ADDR_W = 3;

   // Conversions work on a wide container so any pointer width up to
   // MAX_PTR_W can use them: zero-extend in, truncate the result out.
   // Leading zeros map to leading zeros in both directions.
   localparam int MAX_PTR_W = 32;

   typedef logic [DEF_ADDR_W:0]    ptr_t;
   typedef logic [MAX_PTR_W-1:0]   wptr_t;

   function automatic wptr_t bin2gray(input wptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic wptr_t gray2bin(input wptr_t g);
      wptr_t b;
      b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
      for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/rd_ptr_empty_if.sv
// Read-side bundle between the FIFO consumer and the read pointer stage.
// Latency: wiring only.
// Backpressure: consumer gates rd_en on empty; reads while empty are flagged.
// slave  = read pointer stage (takes rd_en, wr_ptr_gray; drives status).
// master = consumer / write-domain glue (drives rd_en, wr_ptr_gray).
interface rd_ptr_empty_if #(
   parameter int ADDR_W = async_fifo_pkg::DEF_ADDR_W
);
   logic              rd_en;
   logic [ADDR_W:0]   wr_ptr_gray;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   rd_ptr_gray;
   logic              rd_valid;
   logic              empty;
   logic              almost_empty;
   logic [ADDR_W:0]   rd_count;
   logic              underflow;

   modport slave (
      input  rd_en, wr_ptr_gray,
      output rd_addr, rd_ptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
   );

   modport master (
      output rd_en, wr_ptr_gray,
      input  rd_addr, rd_ptr_gray, rd_valid, empty, almost_empty, rd_count, underflow
   );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop clock-domain-crossing synchronizer for Gray-coded buses.
// Latency: STAGES destination clock edges.
// Backpressure: none; samples every edge.
// Ports: i_clk destination clock, i_rst async active-high clear to 0,
//        i_d foreign-domain bus, o_q synchronized bus. STAGES must be >= 2.
module sync_ff #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q [STAGES];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < STAGES; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         r_q[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_q[i] <= r_q[i-1];
         end
      end
   end

   assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_empty.sv
// Read pointer, empty / almost-empty flags and fill count for the async FIFO.
// Latency: rd_valid 1 edge after an accepted read; write visible after SYNC_STAGES+1 edges.
// Backpressure: reads are accepted only while not empty; a read while empty pulses underflow.
// Ports: rclk read clock, rd_rst async active-high reset, bus (slave modport):
//        rd_en/wr_ptr_gray in; rd_addr, rd_ptr_gray, rd_valid, empty,
//        almost_empty, rd_count, underflow out (all registered).
module rd_ptr_empty #(
   parameter int ADDR_W      = async_fifo_pkg::DEF_ADDR_W,
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 1
) (
   input  logic           rclk,
   input  logic           rd_rst,
   rd_ptr_empty_if.slave  bus
);

   import async_fifo_pkg::*;

   localparam int PW = ADDR_W + 1;

   logic [PW-1:0] r_rd_bin;
   logic [PW-1:0] r_rd_gray;
   logic [PW-1:0] r_rd_count;
   logic          r_empty;
   logic          r_almost_empty;
   logic          r_rd_valid;
   logic          r_underflow;

   logic          w_rd_fire;
   logic [PW-1:0] w_rd_bin_next;
   logic [PW-1:0] w_rd_gray_next;
   logic [PW-1:0] w_wq;
   logic [PW-1:0] w_wbin;
   logic [PW-1:0] w_fill_next;

   assign w_rd_fire      = bus.rd_en & ~r_empty;
   assign w_rd_bin_next  = r_rd_bin + {{(PW-1){1'b0}}, w_rd_fire};
   assign w_rd_gray_next = PW'(bin2gray(wptr_t'(w_rd_bin_next)));

   sync_ff #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .i_clk (rclk),
      .i_rst (rd_rst),
      .i_d   (bus.wr_ptr_gray),
      .o_q   (w_wq)
   );

   assign w_wbin = PW'(gray2bin(wptr_t'(w_wq)));

   // Flags are computed from the post-read pointer so the edge that consumes
   // the last entry also raises empty: no over-read and no idle bubble.
   // Modulo subtraction handles pointer wrap; the extra MSB keeps a full lap
   // (difference 2^ADDR_W) distinct from empty (difference 0).
   assign w_fill_next = w_wbin - w_rd_bin_next;

   always_ff @(posedge rclk or posedge rd_rst) begin
      if (rd_rst) begin
         r_rd_bin       <= '0;
         r_rd_gray      <= '0;
         r_rd_count     <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_rd_valid     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_rd_bin       <= w_rd_bin_next;
         r_rd_gray      <= w_rd_gray_next;
         r_rd_count     <= w_fill_next;
         r_empty        <= (w_rd_gray_next == w_wq);
         r_almost_empty <= (w_fill_next <= PW'(AE_THRESH));
         r_rd_valid     <= w_rd_fire;
         r_underflow    <= bus.rd_en & r_empty;
      end
   end

   assign bus.rd_addr      = r_rd_bin[ADDR_W-1:0];
   assign bus.rd_ptr_gray  = r_rd_gray;
   assign bus.rd_count     = r_rd_count;
   assign bus.empty        = r_empty;
   assign bus.almost_empty = r_almost_empty;
   assign bus.rd_valid     = r_rd_valid;
   assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_rd_ptr_empty.sv
// Self-checking bench for rd_ptr_empty: directed scenarios plus a random
// read/write phase, all checked against an occupancy model kept as plain
// integer totals of entries written and read.
module tb_rd_ptr_empty;

   localparam int AW = 3;
   localparam int SS = 2;
   localparam int AE = 1;
   localparam int DEPTH = 1 << AW;
   localparam int LAP   = 2 * DEPTH;

   logic rclk = 1'b0;
   logic rd_rst;

   always #5 rclk = ~rclk;

   rd_ptr_empty_if #(.ADDR_W(AW)) bus ();

   rd_ptr_empty #(
      .ADDR_W      (AW),
      .SYNC_STAGES (SS),
      .AE_THRESH   (AE)
   ) dut (
      .rclk   (rclk),
      .rd_rst (rd_rst),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: totals of entries written / read since reset, and the
   // per-edge history of the write total presented to the DUT.
   int wr_total;
   int rd_total;
   int wr_hist[$];
   bit m_empty;
   int m_count;
   logic [AW:0] prev_gray;
   int wraps_seen;

   function automatic logic [AW:0] ref_gray(input int v);
      int b;
      b = v % LAP;
      return (AW+1)'(b ^ (b >> 1));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rd_total   = 0;
      wr_total   = 0;
      wr_hist    = {};
      m_empty    = 1'b1;
      m_count    = 0;
      prev_gray  = '0;
      wraps_seen = 0;
   endtask

   // One clock: drive inputs, step the model, check every output.
   task automatic step(input bit ren, input int wnext);
      int  visible;
      bit  fire;
      bit  under;
      bus.rd_en       = ren;
      bus.wr_ptr_gray = ref_gray(wnext);
      wr_total        = wnext;
      chk("rd_addr_pre", 32'(bus.rd_addr), 32'(rd_total % DEPTH));
      @(posedge rclk);
      #1;
      wr_hist.push_back(wnext);
      // A write becomes visible SS edges after it is presented.
      visible = (wr_hist.size() > SS) ? wr_hist[wr_hist.size()-1-SS] : 0;
      fire  = ren && !m_empty;
      under = ren && m_empty;
      if (fire) rd_total++;
      m_count = visible - rd_total;
      m_empty = (m_count == 0);
      chk("empty",        32'(bus.empty),        32'(m_empty));
      chk("almost_empty", 32'(bus.almost_empty), 32'(m_count <= AE));
      chk("rd_count",     32'(bus.rd_count),     32'(m_count));
      chk("rd_valid",     32'(bus.rd_valid),     32'(fire));
      chk("underflow",    32'(bus.underflow),    32'(under));
      chk("rd_ptr_gray",  32'(bus.rd_ptr_gray),  32'(ref_gray(rd_total)));
      chk("rd_addr",      32'(bus.rd_addr),      32'(rd_total % DEPTH));
      if (prev_gray == 4'b1000 && bus.rd_ptr_gray == 4'b0000) wraps_seen++;
      prev_gray = bus.rd_ptr_gray;
   endtask

   initial begin
      int w;
      bit ren;

      // Reset state, checked before any clock edge.
      rd_rst          = 1'b1;
      bus.rd_en       = 1'b0;
      bus.wr_ptr_gray = '0;
      #2;
      chk("rst_empty", 32'(bus.empty),        32'd1);
      chk("rst_ae",    32'(bus.almost_empty), 32'd1);
      chk("rst_count", 32'(bus.rd_count),     32'd0);
      chk("rst_addr",  32'(bus.rd_addr),      32'd0);
      chk("rst_gray",  32'(bus.rd_ptr_gray),  32'd0);
      chk("rst_valid", 32'(bus.rd_valid),     32'd0);
      chk("rst_uflow", 32'(bus.underflow),    32'd0);
      @(posedge rclk);
      #1;
      rd_rst = 1'b0;
      model_reset();

      // Sync latency: write pointer 0 -> 1 visible on the 3rd edge.
      step(1'b0, 1);
      chk("sync_e1_empty", 32'(bus.empty), 32'd1);
      step(1'b0, 1);
      chk("sync_e2_empty", 32'(bus.empty), 32'd1);
      step(1'b0, 1);
      chk("sync_e3_empty", 32'(bus.empty),    32'd0);
      chk("sync_e3_count", 32'(bus.rd_count), 32'd1);
      step(1'b1, 1);
      step(1'b0, 1);

      // Four entries pending, then asynchronous reset mid-cycle.
      for (int i = 0; i < 4; i++) step(1'b0, 5);
      chk("pre_rst_count", 32'(bus.rd_count), 32'd4);
      #2;
      rd_rst = 1'b1;
      #1;
      chk("arst_empty", 32'(bus.empty),        32'd1);
      chk("arst_ae",    32'(bus.almost_empty), 32'd1);
      chk("arst_count", 32'(bus.rd_count),     32'd0);
      chk("arst_addr",  32'(bus.rd_addr),      32'd0);
      chk("arst_gray",  32'(bus.rd_ptr_gray),  32'd0);
      bus.wr_ptr_gray = '0;
      bus.rd_en       = 1'b0;
      @(posedge rclk);
      #1;
      rd_rst = 1'b0;
      model_reset();

      // Drain a full FIFO: write pointer jumps to 8 (Gray 1100).
      for (int i = 0; i < 3; i++) step(1'b0, 8);
      chk("full_count", 32'(bus.rd_count), 32'd8);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8);
         chk("drain_valid", 32'(bus.rd_valid), 32'd1);
      end
      chk("drain_empty", 32'(bus.empty),       32'd1);
      chk("drain_gray",  32'(bus.rd_ptr_gray), 32'b1100);

      // Underflow: read while empty.
      step(1'b1, 8);
      chk("uflow_pulse", 32'(bus.underflow),   32'd1);
      chk("uflow_valid", 32'(bus.rd_valid),    32'd0);
      chk("uflow_gray",  32'(bus.rd_ptr_gray), 32'b1100);
      step(1'b0, 8);
      chk("uflow_clear", 32'(bus.underflow),   32'd0);

      // Almost empty threshold crossing: 3 -> 2 -> 1.
      step(1'b0, 9);
      step(1'b0, 10);
      step(1'b0, 11);
      step(1'b0, 11);
      step(1'b0, 11);
      chk("ae_count3", 32'(bus.rd_count), 32'd3);
      step(1'b1, 11);
      chk("ae_at2", 32'(bus.almost_empty), 32'd0);
      step(1'b1, 11);
      chk("ae_at1", 32'(bus.almost_empty), 32'd1);

      // Random traffic across several pointer wraps.
      for (int i = 0; i < 400; i++) begin
         w = wr_total;
         if ((w - rd_total) < DEPTH && $urandom_range(0, 2) != 0) w++;
         ren = ($urandom_range(0, 3) != 0);
         step(ren, w);
      end
      // Stop writing and drain everything still visible.
      for (int i = 0; i < 20; i++) step(1'b1, wr_total);
      chk("final_empty", 32'(bus.empty), 32'd1);
      chk("wrap_count",  32'(wraps_seen), 32'(rd_total / LAP));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rd_ptr_empty.md
# rd_ptr_empty

Read-side pointer and empty-flag generator for the asynchronous FIFO; the read-domain counterpart of the write pointer stage. It brings the write domain's Gray-coded write pointer into the read clock domain through a multi-stage synchronizer. It advances the read pointer on accepted reads and derives registered `empty`, `almost_empty`, and fill-count outputs. It also returns its own Gray pointer for synchronization into the write domain.

## Interface
- `ADDR_W`, 3: RAM address width; FIFO depth is 2^ADDR_W. Pointers are ADDR_W+1 bits wide.
- `SYNC_STAGES`, 2: flip-flop stages in the write-pointer synchronizer; legal values are 2 or more.
- `AE_THRESH`, 1: `almost_empty` asserts when `rd_count <= AE_THRESH`.

- `rclk`  in  1  read-domain clock; all logic is on its rising edge.
- `rd_rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  read request.
- `wr_ptr_gray`  in  ADDR_W+1  Gray-coded write pointer, registered in the write domain.
- `rd_addr`  out  ADDR_W  RAM read address: the low bits of the binary read pointer.
- `rd_ptr_gray`  out  ADDR_W+1  Gray-coded read pointer, registered, sent to the write domain.
- `rd_valid`  out  1  registered strobe, one cycle after an accepted read; RAM data is valid.
- `empty`  out  1  registered empty flag.
- `almost_empty`  out  1  registered flag, `rd_count <= AE_THRESH`.
- `rd_count`  out  ADDR_W+1  fill level as seen from the read domain.
- `underflow`  out  1  one-cycle pulse on a read attempt while empty.

## Operation
- Reset values: `rd_rst` clears every register asynchronously.
  - Pointers, `rd_addr`, `rd_ptr_gray`, `rd_count`, `rd_valid`, `underflow` and all synchronizer flops go to 0.
  - `empty` and `almost_empty` go to 1.
- Accept: `rd_fire = rd_en & ~empty`. On `rd_fire`, `rd_bin_next = rd_bin + 1`, modulo 2^(ADDR_W+1).
- Gray conversion: `rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1)`. `rd_ptr_gray` is registered from `rd_gray_next`; it is never derived combinationally.
- Synchronizer: `wr_ptr_gray` passes through SYNC_STAGES flops, giving `wq`. `wq` is converted Gray to binary, giving `wbin`.
- Empty: `empty <= (rd_gray_next == wq)`, registered on the same edge as the pointer update.
- Count: `rd_count <= wbin - rd_bin_next`, modulo 2^(ADDR_W+1). For a well-formed input the result never exceeds 2^ADDR_W.
- Almost empty: `almost_empty <= (wbin - rd_bin_next) <= AE_THRESH`.
- Underflow: `underflow <= rd_en & empty`. The pointer does not move.
- Valid: `rd_valid <= rd_fire`.
- Wrap-around: the pointer rolls over from 2^(ADDR_W+1)-1 to 0, a single-bit Gray change. The MSB distinguishes a full lap from empty.

## Timing
- Read latency: `rd_addr` is presented in the cycle `rd_fire` is high and advances on the next edge. `rd_valid` is high in that following cycle.
- Back-to-back reads are supported every cycle until `empty` asserts. `empty` asserts on the same edge that consumes the last entry, so no bubble and no over-read can occur.
- Write-to-visible latency: a change on `wr_ptr_gray` affects `empty` and `rd_count` SYNC_STAGES+1 rising edges later (3 edges by default).
- Simultaneous events:
  - A write becoming visible on the same edge as a read: `empty` and `rd_count` reflect both.
  - Read and reset together: reset wins.
- Reset mid-operation: outputs take their reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after `rd_rst` deasserts.

## Structure
- Shared package `async_fifo_pkg` holds:
  - the `bin2gray` and `gray2bin` functions;
  - the default `ADDR_W` constant;
  - a `ptr_t` typedef of width ADDR_W+1.
  
  The write pointer stage uses the same package.
- One sub-module, `sync_ff`: a parameterized SYNC_STAGES-deep, width-generic synchronizer with asynchronous active-high reset to 0. The write domain reuses it for `rd_ptr_gray`.

## Test plan
- Reset: pulse `rd_rst` mid-stream with 4 entries pending. Immediately `empty`=1, `almost_empty`=1, `rd_count`=0, `rd_addr`=0 and `rd_ptr_gray`=0, with no clock edge needed.
- Sync latency: step `wr_ptr_gray` from 0000 to 0001. `empty` falls and `rd_count`=1 exactly on the 3rd `rclk` edge.
- Drain full: set `wr_ptr_gray`=1100 (binary 8), wait for sync, then hold `rd_en` for 8 cycles.
  - `rd_addr` steps 0..7 and `rd_valid` is high for 8 cycles.
  - `empty` rises on the 8th accepting edge, with `rd_ptr_gray`=1100.
- Underflow: drive `rd_en`=1 while empty. `underflow` pulses for one cycle, the pointer is unchanged and `rd_valid` stays 0.
- Wrap: advance write and read through 18 entries. The binary pointer passes 15 to 0, `rd_ptr_gray` goes 1000 to 0000, and `rd_count` stays correct throughout.
- Almost empty, with AE_THRESH=1: `rd_count` 3 to 2 leaves `almost_empty`=0; 2 to 1 sets it to 1 on the same edge.
